// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor (data1 - data2), LSB first.
// One full-subtractor cell plus a borrow flop. A start/done handshake launches
// an operation and delivers the difference, final borrow and zero flag.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    logic [WIDTH-1:0] b_reg,      b_next;
    logic [WIDTH-1:0] diff_reg,   diff_next;
    logic             br_reg,     br_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             borrow_reg, borrow_next;
    logic             zero_reg,   zero_next;

    // Full-subtractor cell operating on the current LSBs and the borrow flop.
    logic             bit_a;
    logic             bit_b;
    logic             d_bit;
    logic             br_bit;
    logic [WIDTH-1:0] diff_shift;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

    assign bit_a  = a_reg[0];
    assign bit_b  = b_reg[0];
    assign d_bit  = bit_a ^ bit_b ^ br_reg;
    assign br_bit = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);

    // Difference fills from the MSB end so that after WIDTH shifts bit 0 of
    // the first cycle lands in bit 0 of the result.
    assign diff_shift = {d_bit, diff_reg[WIDTH-1:1]};

    // Operand shift registers move right by one per RUN cycle, zero-filled.
    assign a_shift[WIDTH-1] = 1'b0;
    assign b_shift[WIDTH-1] = 1'b0;
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_shift[gi] = a_reg[gi+1];
            assign b_shift[gi] = b_reg[gi+1];
        end
    endgenerate

    // Next-state and datapath update; every register holds unless told otherwise.
    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        diff_next   = diff_reg;
        br_next     = br_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        borrow_next = borrow_reg;
        zero_next   = zero_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = data1;
                    b_next     = data2;
                    diff_next  = '0;
                    br_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_next    = a_shift;
                b_next    = b_shift;
                diff_next = diff_shift;
                br_next   = br_bit;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == LAST_BIT) begin
                    // Publish using the value being shifted in this cycle.
                    result_next = diff_shift;
                    borrow_next = br_bit;
                    zero_next   = (diff_shift == '0);
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            borrow_reg <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            diff_reg   <= diff_next;
            br_reg     <= br_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            borrow_reg <= borrow_next;
            zero_reg   <= zero_next;
        end
    end

    // Status decodes come straight from the state register.
    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign borrow = borrow_reg;
    assign zero   = zero_reg;

endmodule
